vga_char_buf_port2_sched: RTL and testbench
===========================================

Name: vga_char_buf_port2_sched

Overview:
- Owns port 2 (s2) of the 2048x32 character-buffer on-chip SRAM and shares it between two requesters.
- Requester one is the video character-fetch path, which has strict priority.
- Requester two is a hardware clear engine that fills the whole buffer with a fill word on command.
- Sits between the VGA character pixel pipeline, the CSR block and the dual-port RAM; port 1 (s1) stays with the CPU and is unaffected.

Parameters:
- ADDR_W, 11, word address width of the RAM.
- DATA_W, 32, RAM word width.
- DEPTH, 2048, number of words cleared; must equal 2**ADDR_W.
- BE_W, 4, byte-enable width (DATA_W/8).

Ports:
- clk  in  1  system clock; the RAM is clocked by the same clock.
- reset  in  1  asynchronous, active-high reset.
- vid_req  in  1  video fetch request for this cycle.
- vid_addr  in  ADDR_W  video fetch word address.
- vid_grant  out  1  the video request is issued to the RAM this cycle.
- vid_rdata_valid  out  1  vid_rdata holds the data for the request granted last cycle.
- vid_rdata  out  DATA_W  read data from the RAM.
- clr_start  in  1  single-cycle pulse that starts a full-buffer clear.
- clr_fill  in  DATA_W  fill word, sampled when clr_start is accepted.
- clr_busy  out  1  a clear is in progress.
- clr_done  out  1  one-cycle pulse when the clear completes.
- mem_address2  out  ADDR_W  RAM port 2 address.
- mem_chipselect2  out  1  RAM port 2 chip select.
- mem_write2  out  1  RAM port 2 write.
- mem_byteenable2  out  BE_W  RAM port 2 byte enables.
- mem_writedata2  out  DATA_W  RAM port 2 write data.
- mem_clken2  out  1  RAM port 2 clock enable; held at 1.
- mem_readdata2  in  DATA_W  RAM port 2 read data.

Behaviour:
- Reset (async assert, sync release):
  - State is IDLE; clear counter = 0; fill register = 0.
  - clr_busy = 0, clr_done = 0, vid_rdata_valid = 0.
  - All mem_* control outputs = 0 except mem_clken2 = 1.
- RAM timing:
  - The RAM registers its address and control internally, so mem_* outputs are driven combinationally from the current-cycle grant.
  - Read data appears on mem_readdata2 exactly 1 cycle after the grant.
- Arbitration (combinational, fixed priority):
  - vid_req = 1: vid_grant = 1; mem_chipselect2 = 1, mem_write2 = 0, mem_address2 = vid_addr, mem_byteenable2 = 4'hF.
  - Otherwise, in state CLEAR: mem_chipselect2 = 1, mem_write2 = 1, mem_address2 = clear counter, mem_writedata2 = fill register, mem_byteenable2 = 4'hF.
  - Otherwise: mem_chipselect2 = 0 and mem_write2 = 0.
- Video return path:
  - vid_rdata_valid is vid_grant registered by one cycle.
  - vid_rdata = mem_readdata2, passed straight through.
  - Read latency is 1 cycle; back-to-back grants give data every cycle.
- FSM, states IDLE, CLEAR, DONE:
  - IDLE -> CLEAR on clr_start. Load the fill register from clr_fill and set the counter to 0.
  - CLEAR: each cycle with no vid_req, write one word and increment the counter. A cycle with vid_req stalls the counter (no write, no increment).
  - CLEAR -> DONE on the cycle the write to address DEPTH-1 is issued. The counter wraps to 0.
  - DONE -> IDLE after one cycle; clr_done = 1 only while in DONE.
- clr_busy = 1 in CLEAR and DONE.
- clr_start while clr_busy = 1 is ignored; the fill register is not reloaded.
- clr_start in the DONE cycle is also ignored.
- Video has unbounded priority. A clear completes in DEPTH + (number of video grants during CLEAR) cycles.
- Reset mid-clear aborts immediately: the buffer is left partially cleared and clr_done does not pulse.
- Unused mem_writedata2 during reads is don't-care; drive it from the fill register.

Optional Feature:
- Macro: VGA_CHARBUF_CLR_IRQ_EN.
- Defined:
  - Adds input irq_ack (1 bit) and output clr_irq (1 bit).
  - clr_irq is set on the clr_done pulse and held until an irq_ack pulse.
  - If set and ack occur in the same cycle, set wins.
  - clr_irq resets to 0.
- Not defined: the ports are absent and there is no interrupt logic.

Decomposition:
- Shared package vga_char_buf_pkg holds:
  - the state enum (IDLE, CLEAR, DONE);
  - constants CHARBUF_ADDR_W = 11, CHARBUF_DATA_W = 32, CHARBUF_DEPTH = 2048;
  - CHARBUF_SPACE_FILL = 32'h20202020.
- One sub-module, vga_char_buf_clear_engine: FSM, counter, fill register, busy/done, and the optional irq. It receives an advance/stall input from the arbiter.
- Arbitration and the mux stay in the top level.

Test Plan:
- Reset with vid_req = 1 asserted -> every output is at its reset value.
- After release, video read of addr 0x005 whose RAM word is 0x41424344 -> vid_grant in cycle N; vid_rdata_valid = 1 and vid_rdata = 0x41424344 in cycle N+1.
- clr_start with clr_fill = 0x20202020 and no video -> clr_busy rises next cycle; 2048 consecutive writes to addresses 0..0x7FF; clr_done pulses once in cycle 2049; the RAM reads back all spaces.
- Clear with video requests every 4th cycle -> no write in any granted cycle; clear completes in 2048 + 512 cycles; no address is skipped or written twice.
- clr_start again mid-clear with clr_fill = 0 -> ignored; the final content is still the original fill word.
- Assert reset at counter 0x400 -> clr_busy = 0 immediately; no clr_done; words 0x400..0x7FF unchanged. With VGA_CHARBUF_CLR_IRQ_EN, a full clear sets clr_irq and irq_ack clears it.

Source files
------------

// File: rtl/vga_char_buf_pkg.sv
// Shared types and constants for the character-buffer port-2 scheduler.
package vga_char_buf_pkg;

  localparam int unsigned CHARBUF_ADDR_W = 11;
  localparam int unsigned CHARBUF_DATA_W = 32;
  localparam int unsigned CHARBUF_DEPTH  = 2048;

  localparam logic [31:0] CHARBUF_SPACE_FILL = 32'h20202020;

  typedef enum logic [1:0] {
    StIdle,
    StClear,
    StDone
  } clr_state_e;

endpackage

// File: rtl/vga_char_buf_clear_engine.sv
// Full-buffer clear sequencer: FSM, word counter, fill register and busy/done.
// Optional sticky completion interrupt under VGA_CHARBUF_CLR_IRQ_EN.
module vga_char_buf_clear_engine
  import vga_char_buf_pkg::*;
#(
  parameter int unsigned ADDR_W = CHARBUF_ADDR_W,
  parameter int unsigned DATA_W = CHARBUF_DATA_W,
  parameter int unsigned DEPTH  = CHARBUF_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic [DATA_W-1:0] fill_i,
  input  logic              advance_i,
`ifdef VGA_CHARBUF_CLR_IRQ_EN
  input  logic              irq_ack_i,
  output logic              irq_o,
`endif
  output logic              clearing_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] fill_o
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] fill_q, fill_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
    end
  end

  // start_i is only honoured in idle, so restarts mid-clear leave the fill word alone.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StClear;
          fill_d  = fill_i;
          cnt_d   = '0;
        end
      end
      StClear: begin
        if (advance_i) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastAddr) begin
            state_d = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    clearing_o = (state_q == StClear);
    done_o     = (state_q == StDone);
    busy_o     = (state_q == StClear) || (state_q == StDone);
    addr_o     = cnt_q;
    fill_o     = fill_q;
  end

`ifdef VGA_CHARBUF_CLR_IRQ_EN
  logic irq_q, irq_d;

  // A completion coinciding with an acknowledge keeps the interrupt pending.
  always_comb begin
    irq_d = irq_q;
    if (state_q == StDone) begin
      irq_d = 1'b1;
    end else if (irq_ack_i) begin
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq_o = irq_q;
`endif

endmodule

// File: rtl/vga_char_buf_port2_sched.sv
// Port-2 scheduler for the character-buffer RAM: video fetch has strict priority,
// the clear engine fills idle cycles. Optional clear interrupt: VGA_CHARBUF_CLR_IRQ_EN.
module vga_char_buf_port2_sched
  import vga_char_buf_pkg::*;
#(
  parameter int unsigned ADDR_W = CHARBUF_ADDR_W,
  parameter int unsigned DATA_W = CHARBUF_DATA_W,
  parameter int unsigned DEPTH  = CHARBUF_DEPTH,
  parameter int unsigned BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_grant,
  output logic              vid_rdata_valid,
  output logic [DATA_W-1:0] vid_rdata,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_fill,
  output logic              clr_busy,
  output logic              clr_done,
`ifdef VGA_CHARBUF_CLR_IRQ_EN
  input  logic              irq_ack,
  output logic              clr_irq,
`endif
  output logic [ADDR_W-1:0] mem_address2,
  output logic              mem_chipselect2,
  output logic              mem_write2,
  output logic [BE_W-1:0]   mem_byteenable2,
  output logic [DATA_W-1:0] mem_writedata2,
  output logic              mem_clken2,
  input  logic [DATA_W-1:0] mem_readdata2
);

  logic              clearing;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] clr_wdata;
  logic              vid_valid_q;

  vga_char_buf_clear_engine #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_clear_engine (
    .clk        (clk),
    .reset      (reset),
    .start_i    (clr_start),
    .fill_i     (clr_fill),
    .advance_i  (~vid_grant),
`ifdef VGA_CHARBUF_CLR_IRQ_EN
    .irq_ack_i  (irq_ack),
    .irq_o      (clr_irq),
`endif
    .clearing_o (clearing),
    .busy_o     (clr_busy),
    .done_o     (clr_done),
    .addr_o     (clr_addr),
    .fill_o     (clr_wdata)
  );

  // The RAM registers its inputs, so the port is driven straight from this cycle's grant.
  // Grant is masked by reset so the port stays quiet while reset is held.
  always_comb begin
    vid_grant       = vid_req & ~reset;
    mem_chipselect2 = vid_grant | clearing;
    mem_write2      = clearing & ~vid_grant;
    mem_address2    = '0;
    if (vid_grant) begin
      mem_address2 = vid_addr;
    end else if (clearing) begin
      mem_address2 = clr_addr;
    end
    mem_byteenable2 = mem_chipselect2 ? {BE_W{1'b1}} : '0;
    mem_writedata2  = clr_wdata;
    mem_clken2      = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vid_valid_q <= 1'b0;
    end else begin
      vid_valid_q <= vid_grant;
    end
  end

  assign vid_rdata_valid = vid_valid_q;
  assign vid_rdata       = mem_readdata2;

endmodule

// File: tb/tb_vga_char_buf_port2_sched.sv
// Directed self-checking bench for vga_char_buf_port2_sched with a 1-cycle-latency RAM model.
module tb_vga_char_buf_port2_sched;
  import vga_char_buf_pkg::*;

  logic        clk;
  logic        reset;
  logic        vid_req;
  logic [10:0] vid_addr;
  logic        vid_grant;
  logic        vid_rdata_valid;
  logic [31:0] vid_rdata;
  logic        clr_start;
  logic [31:0] clr_fill;
  logic        clr_busy;
  logic        clr_done;
`ifdef VGA_CHARBUF_CLR_IRQ_EN
  logic        irq_ack;
  logic        clr_irq;
`endif
  logic [10:0] mem_address2;
  logic        mem_chipselect2;
  logic        mem_write2;
  logic [3:0]  mem_byteenable2;
  logic [31:0] mem_writedata2;
  logic        mem_clken2;
  logic [31:0] mem_readdata2;

  int total;
  int bad;

  logic [31:0] mem    [2048];
  int          wr_cnt [2048];
  logic        do_init;

  vga_char_buf_port2_sched dut (
    .clk             (clk),
    .reset           (reset),
    .vid_req         (vid_req),
    .vid_addr        (vid_addr),
    .vid_grant       (vid_grant),
    .vid_rdata_valid (vid_rdata_valid),
    .vid_rdata       (vid_rdata),
    .clr_start       (clr_start),
    .clr_fill        (clr_fill),
    .clr_busy        (clr_busy),
    .clr_done        (clr_done),
`ifdef VGA_CHARBUF_CLR_IRQ_EN
    .irq_ack         (irq_ack),
    .clr_irq         (clr_irq),
`endif
    .mem_address2    (mem_address2),
    .mem_chipselect2 (mem_chipselect2),
    .mem_write2      (mem_write2),
    .mem_byteenable2 (mem_byteenable2),
    .mem_writedata2  (mem_writedata2),
    .mem_clken2      (mem_clken2),
    .mem_readdata2   (mem_readdata2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] pat(input int i);
    if (i == 5) return 32'h41424344;
    return 32'hC0DE0000 | i;
  endfunction

  // RAM model: registered read data, byte-enabled writes, per-word write counter.
  always @(posedge clk) begin
    if (do_init) begin
      for (int i = 0; i < 2048; i++) begin
        mem[i]    <= pat(i);
        wr_cnt[i] <= 0;
      end
    end else if (mem_chipselect2 && mem_clken2) begin
      if (mem_write2) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_byteenable2[b]) mem[mem_address2][8*b +: 8] <= mem_writedata2[8*b +: 8];
        end
        wr_cnt[mem_address2] <= wr_cnt[mem_address2] + 1;
      end else begin
        mem_readdata2 <= mem[mem_address2];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic init_ram();
    step();
    do_init = 1'b1;
    step();
    do_init = 1'b0;
  endtask

  function automatic int count_bad_words(input int lo, input int hi, input logic [31:0] fill,
                                         input bit use_pat);
    int n = 0;
    for (int i = lo; i <= hi; i++) begin
      if (mem[i] !== (use_pat ? pat(i) : fill)) n++;
    end
    return n;
  endfunction

  function automatic int count_bad_writes();
    int n = 0;
    for (int i = 0; i < 2048; i++) begin
      if (wr_cnt[i] != 1) n++;
    end
    return n;
  endfunction

  task automatic test_reset();
    reset     = 1'b1;
    vid_req   = 1'b1;
    vid_addr  = 11'h005;
    clr_start = 1'b1;
    clr_fill  = 32'hFFFFFFFF;
    step();
    step();
    total++;
    if (vid_grant !== 1'b0 || vid_rdata_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_vid: grant=%b valid=%b want 0 0", vid_grant, vid_rdata_valid);
    end
    total++;
    if (clr_busy !== 1'b0 || clr_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_clr: busy=%b done=%b want 0 0", clr_busy, clr_done);
    end
    total++;
    if (mem_chipselect2 !== 1'b0 || mem_write2 !== 1'b0 || mem_byteenable2 !== 4'h0 ||
        mem_address2 !== 11'h000 || mem_writedata2 !== 32'h0 || mem_clken2 !== 1'b1) begin
      bad++;
      $display("FAIL reset_mem: cs=%b we=%b be=%h a=%h wd=%h ck=%b want 0 0 0 0 0 1",
               mem_chipselect2, mem_write2, mem_byteenable2, mem_address2, mem_writedata2,
               mem_clken2);
    end
`ifdef VGA_CHARBUF_CLR_IRQ_EN
    total++;
    if (clr_irq !== 1'b0) begin
      bad++;
      $display("FAIL reset_irq: irq=%b want 0", clr_irq);
    end
`endif
    vid_req   = 1'b0;
    clr_start = 1'b0;
    clr_fill  = 32'h0;
    step();
    reset = 1'b0;
    init_ram();
  endtask

  task automatic test_video_read();
    step();
    vid_req  = 1'b1;
    vid_addr = 11'h005;
    #1;
    total++;
    if (vid_grant !== 1'b1 || mem_chipselect2 !== 1'b1 || mem_write2 !== 1'b0 ||
        mem_address2 !== 11'h005 || mem_byteenable2 !== 4'hF) begin
      bad++;
      $display("FAIL vid_issue: g=%b cs=%b we=%b a=%h be=%h want 1 1 0 005 F", vid_grant,
               mem_chipselect2, mem_write2, mem_address2, mem_byteenable2);
    end
    step();
    vid_req = 1'b0;
    #1;
    total++;
    if (vid_rdata_valid !== 1'b1 || vid_rdata !== 32'h41424344 || vid_grant !== 1'b0) begin
      bad++;
      $display("FAIL vid_data: valid=%b data=%h g=%b want 1 41424344 0", vid_rdata_valid,
               vid_rdata, vid_grant);
    end
  endtask

  task automatic test_back_to_back();
    int errs = 0;
    for (int j = 0; j < 5; j++) begin
      step();
      vid_req  = (j < 3);
      vid_addr = 11'(6 + j);
      #1;
      if (j >= 1 && j <= 3) begin
        if (vid_rdata_valid !== 1'b1 || vid_rdata !== pat(5 + j)) errs++;
      end else if (vid_rdata_valid !== 1'b0) begin
        errs++;
      end
    end
    vid_req = 1'b0;
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL back_to_back: %0d bad cycles, want 0", errs);
    end
  endtask

  task automatic test_full_clear();
    int done_k = 0;
    int errs   = 0;
    step();
    clr_start = 1'b1;
    clr_fill  = CHARBUF_SPACE_FILL;
    #1;
    total++;
    if (clr_busy !== 1'b0) begin
      bad++;
      $display("FAIL clr_start_cycle: busy=%b want 0", clr_busy);
    end
    for (int k = 1; k <= 5000; k++) begin
      step();
      clr_start = 1'b0;
      #1;
      if (clr_done === 1'b1) begin
        done_k    = k;
        clr_start = 1'b1;
        clr_fill  = 32'h0;
        break;
      end
      if (clr_busy !== 1'b1 || mem_write2 !== 1'b1 || mem_address2 !== 11'(k - 1)) errs++;
    end
    total++;
    if (done_k != 2049) begin
      bad++;
      $display("FAIL clr_done_cycle: done at %0d want 2049", done_k);
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL clr_write_seq: %0d bad cycles, want 0", errs);
    end
    step();
    clr_start = 1'b0;
    #1;
    total++;
    if (clr_busy !== 1'b0 || clr_done !== 1'b0) begin
      bad++;
      $display("FAIL clr_after_done: busy=%b done=%b want 0 0", clr_busy, clr_done);
    end
    step();
    #1;
    total++;
    if (clr_busy !== 1'b0) begin
      bad++;
      $display("FAIL start_in_done: busy=%b want 0", clr_busy);
    end
    total++;
    if (count_bad_words(0, 2047, CHARBUF_SPACE_FILL, 1'b0) != 0 || count_bad_writes() != 0) begin
      bad++;
      $display("FAIL clr_contents: bad words=%0d bad counts=%0d want 0 0",
               count_bad_words(0, 2047, CHARBUF_SPACE_FILL, 1'b0), count_bad_writes());
    end
  endtask

  task automatic test_clear_with_video();
    int done_k = 0;
    int grants = 0;
    int gerrs  = 0;
    int werrs  = 0;
    int verrs  = 0;
    bit prev_g = 1'b0;
    init_ram();
    step();
    clr_start = 1'b1;
    clr_fill  = 32'h5A5A5A5A;
    for (int k = 1; k <= 6000; k++) begin
      step();
      clr_start = (k == 1001);
      if (k == 1001) clr_fill = 32'h0;
      vid_req  = (k % 4 == 0) && (k <= 2048);
      vid_addr = 11'(k);
      #1;
      if (vid_rdata_valid !== prev_g) verrs++;
      prev_g = vid_req;
      if (vid_req) begin
        grants++;
        if (vid_grant !== 1'b1 || mem_write2 !== 1'b0 || mem_address2 !== 11'(k)) gerrs++;
      end else if (clr_done === 1'b1) begin
        done_k = k;
        break;
      end else if (mem_write2 !== 1'b1) begin
        werrs++;
      end
    end
    step();
    vid_req   = 1'b0;
    clr_start = 1'b0;
    total++;
    if (done_k != 2561 || grants != 512) begin
      bad++;
      $display("FAIL vidclr_len: done at %0d grants=%0d want 2561 512", done_k, grants);
    end
    total++;
    if (gerrs != 0 || werrs != 0 || verrs != 0) begin
      bad++;
      $display("FAIL vidclr_port: grant errs=%0d write errs=%0d valid errs=%0d want 0 0 0",
               gerrs, werrs, verrs);
    end
    total++;
    if (count_bad_words(0, 2047, 32'h5A5A5A5A, 1'b0) != 0 || count_bad_writes() != 0) begin
      bad++;
      $display("FAIL vidclr_contents: bad words=%0d bad counts=%0d want 0 0",
               count_bad_words(0, 2047, 32'h5A5A5A5A, 1'b0), count_bad_writes());
    end
  endtask

  task automatic test_reset_mid_clear();
    int errs = 0;
    init_ram();
    step();
    clr_start = 1'b1;
    clr_fill  = 32'h11111111;
    for (int k = 1; k <= 1025; k++) begin
      step();
      clr_start = 1'b0;
      #1;
      if (k == 1025) begin
        total++;
        if (mem_write2 !== 1'b1 || mem_address2 !== 11'h400) begin
          bad++;
          $display("FAIL mid_addr: we=%b a=%h want 1 400", mem_write2, mem_address2);
        end
        reset = 1'b1;
        #1;
        total++;
        if (clr_busy !== 1'b0 || mem_chipselect2 !== 1'b0 || clr_done !== 1'b0) begin
          bad++;
          $display("FAIL mid_reset: busy=%b cs=%b done=%b want 0 0 0", clr_busy,
                   mem_chipselect2, clr_done);
        end
      end
    end
    step();
    step();
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (clr_done !== 1'b0 || clr_busy !== 1'b0) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL mid_no_done: %0d cycles with done/busy, want 0", errs);
    end
    total++;
    if (count_bad_words(0, 1023, 32'h11111111, 1'b0) != 0 ||
        count_bad_words(1024, 2047, 32'h0, 1'b1) != 0) begin
      bad++;
      $display("FAIL mid_contents: low bad=%0d high bad=%0d want 0 0",
               count_bad_words(0, 1023, 32'h11111111, 1'b0),
               count_bad_words(1024, 2047, 32'h0, 1'b1));
    end
  endtask

`ifdef VGA_CHARBUF_CLR_IRQ_EN
  task automatic test_irq();
    int done_k = 0;
    step();
    clr_start = 1'b1;
    clr_fill  = 32'h33333333;
    for (int k = 1; k <= 5000; k++) begin
      step();
      clr_start = 1'b0;
      #1;
      if (clr_done === 1'b1) begin
        done_k  = k;
        irq_ack = 1'b1;
        break;
      end
    end
    total++;
    if (done_k != 2049 || clr_irq !== 1'b0) begin
      bad++;
      $display("FAIL irq_pre: done at %0d irq=%b want 2049 0", done_k, clr_irq);
    end
    step();
    #1;
    total++;
    if (clr_irq !== 1'b1) begin
      bad++;
      $display("FAIL irq_set_wins: irq=%b want 1", clr_irq);
    end
    step();
    irq_ack = 1'b0;
    #1;
    total++;
    if (clr_irq !== 1'b0) begin
      bad++;
      $display("FAIL irq_ack: irq=%b want 0", clr_irq);
    end
  endtask
`endif

  initial begin
    total     = 0;
    bad       = 0;
    do_init   = 1'b0;
    reset     = 1'b1;
    vid_req   = 1'b0;
    vid_addr  = '0;
    clr_start = 1'b0;
    clr_fill  = '0;
`ifdef VGA_CHARBUF_CLR_IRQ_EN
    irq_ack   = 1'b0;
`endif
    test_reset();
    test_video_read();
    test_back_to_back();
    test_full_clear();
    test_clear_with_video();
    test_reset_mid_clear();
`ifdef VGA_CHARBUF_CLR_IRQ_EN
    test_irq();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
